mdu_unit: RTL and testbench

- Multiply/divide unit in the EX stage, beside the ALU; shares the ALU's forwarded A/B operands.
- Executes MIPS mult/multu/div/divu over several cycles and holds the architectural HI/LO registers.
- Services mthi/mtlo writes.
- Drives busy so hazard logic stalls any MDU instruction in ID while busy or start is high; mfhi/mflo read HI/LO directly.

---
 rtl/mdu_unit.sv | 102 ++++++++++
 tb/tb_mdu_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at launch and committed to HI/LO when the busy countdown expires.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_W = 8;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    logic [CNT_W-1:0]   count;
    logic [31:0]        pending_hi_p1;
    logic [31:0]        pending_lo_p1;
    logic signed [63:0] prod_s_p0;
    logic [63:0]        prod_u_p0;
    logic [63:0]        sdiv_p0;
    logic [63:0]        udiv_p0;

    // Signed divide via magnitudes; returns {remainder, quotient}. The
    // 0x80000000 / -1 case wraps naturally to quotient 0x80000000, remainder 0.
    function automatic logic [63:0] sdiv(input logic signed [31:0] n,
                                         input logic signed [31:0] d);
        logic [31:0] un, ud, uq, ur;
        un = n[31] ? (~$unsigned(n) + 32'd1) : $unsigned(n);
        ud = d[31] ? (~$unsigned(d) + 32'd1) : $unsigned(d);
        uq = un / ud;
        ur = un % ud;
        if (n[31] ^ d[31]) uq = ~uq + 32'd1;
        if (n[31])         ur = ~ur + 32'd1;
        return {ur, uq};
    endfunction

    always_comb begin
        prod_s_p0 = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u_p0 = {32'd0, A} * {32'd0, B};
        sdiv_p0   = {HI, LO};
        udiv_p0   = {HI, LO};
        // A zero divisor leaves HI/LO as they are when the op completes.
        if (B != 32'd0) begin
            sdiv_p0 = sdiv($signed(A), $signed(B));
            udiv_p0 = {A % B, A / B};
        end
    end

    assign busy = (count != '0);

    // Stage p1: pending result held until the countdown reaches one.
    always_ff @(posedge clk) begin
        if (reset) begin
            count         <= '0;
            pending_hi_p1 <= '0;
            pending_lo_p1 <= '0;
            HI            <= '0;
            LO            <= '0;
        end else if (busy) begin
            if (count == CNT_W'(1)) begin
                HI <= pending_hi_p1;
                LO <= pending_lo_p1;
            end
            count <= count - CNT_W'(1);
        end else if (start) begin
            case (op)
                OP_MULT: begin
                    {pending_hi_p1, pending_lo_p1} <= prod_s_p0;
                    count <= CNT_W'(MULT_CYCLES);
                end
                OP_MULTU: begin
                    {pending_hi_p1, pending_lo_p1} <= prod_u_p0;
                    count <= CNT_W'(MULT_CYCLES);
                end
                OP_DIV: begin
                    {pending_hi_p1, pending_lo_p1} <= sdiv_p0;
                    count <= CNT_W'(DIV_CYCLES);
                end
                OP_DIVU: begin
                    {pending_hi_p1, pending_lo_p1} <= udiv_p0;
                    count <= CNT_W'(DIV_CYCLES);
                end
                OP_MTHI: HI <= A;
                OP_MTLO: LO <= A;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: scoreboard of expected {HI,LO} per launched op.
module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        tick();
        start = 1'b0; op = 4'd0;
    endtask

    // Counts busy cycles from the current cycle and reports whether HI/LO moved meanwhile.
    task automatic wait_idle(output int cycles, output bit held);
        logic [31:0] h0, l0;
        h0 = HI; l0 = LO;
        cycles = 0; held = 1'b1;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            if (HI !== h0 || LO !== l0) held = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 4'd0; A = '0; B = '0;
        tick();
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b HI=%h LO=%h, required 0/0/0", busy, HI, LO);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: busy=%b HI=%h LO=%h, required 0/0/0", i, busy, HI, LO);
            end
        end
    endtask

    task automatic test_mult();
        int cyc; bit held; logic [63:0] e;
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
        launch(4'd1, 32'hFFFFFFFE, 32'd3);
        wait_idle(cyc, held);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc != 5) begin n_fail++; $display("FAIL mult_busy: got %0d cycles, required 5", cyc); end
        n_checks++;
        if (!held) begin n_fail++; $display("FAIL mult_hold: HI/LO changed while busy"); end
        n_checks++;
        if ({HI, LO} !== e) begin n_fail++; $display("FAIL mult_result: got %h_%h, required %h", HI, LO, e); end

        exp_q.push_back({32'h00000002, 32'hFFFFFFFA});
        launch(4'd2, 32'hFFFFFFFE, 32'd3);
        wait_idle(cyc, held);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc != 5) begin n_fail++; $display("FAIL multu_busy: got %0d cycles, required 5", cyc); end
        n_checks++;
        if ({HI, LO} !== e) begin n_fail++; $display("FAIL multu_result: got %h_%h, required %h", HI, LO, e); end
    endtask

    task automatic test_div();
        int cyc; bit held; logic [63:0] e;
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        launch(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(cyc, held);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc != 10) begin n_fail++; $display("FAIL div_busy: got %0d cycles, required 10", cyc); end
        n_checks++;
        if (!held) begin n_fail++; $display("FAIL div_hold: HI/LO changed while busy"); end
        n_checks++;
        if ({HI, LO} !== e) begin n_fail++; $display("FAIL div_result: got %h_%h, required %h", HI, LO, e); end

        exp_q.push_back({32'd1, 32'd3});
        launch(4'd4, 32'd7, 32'd2);
        wait_idle(cyc, held);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc != 10 || {HI, LO} !== e) begin
            n_fail++; $display("FAIL divu_result: got %0d cyc %h_%h, required 10 cyc %h", cyc, HI, LO, e);
        end

        exp_q.push_back({32'd0, 32'h80000000});
        launch(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(cyc, held);
        e = exp_q.pop_front();
        n_checks++;
        if ({HI, LO} !== e) begin n_fail++; $display("FAIL div_overflow: got %h_%h, required %h", HI, LO, e); end
    endtask

    task automatic test_random();
        int cyc; bit held; logic [63:0] e;
        logic [3:0] o; logic [31:0] a, b;
        int sa, sb;
        longint sp;
        for (int i = 0; i < 8; i++) begin
            o = 4'($urandom_range(1, 4));
            a = $urandom; b = $urandom;
            if (i % 3 == 0) b = b >> 24;
            if (o >= 4'd3 && b == 32'd0) b = 32'd1;
            if (o == 4'd3 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            sa = a; sb = b;
            case (o)
                4'd1: begin sp = longint'(sa) * longint'(sb); e = sp; end
                4'd2: e = 64'(a) * 64'(b);
                4'd3: e = {32'(sa % sb), 32'(sa / sb)};
                default: e = {a % b, a / b};
            endcase
            exp_q.push_back(e);
            launch(o, a, b);
            wait_idle(cyc, held);
            e = exp_q.pop_front();
            n_checks++;
            if (cyc != ((o <= 4'd2) ? 5 : 10) || {HI, LO} !== e) begin
                n_fail++;
                $display("FAIL random[%0d] op%0d %h,%h: got %0d cyc %h_%h, required %h", i, o, a, b, cyc, HI, LO, e);
            end
        end
    endtask

    task automatic test_div_zero();
        int cyc; bit held; logic [63:0] e;
        launch(4'd5, 32'h11, 32'd0);
        n_checks++;
        if (HI !== 32'h11 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mthi: got HI=%h busy=%b, required 11/0", HI, busy);
        end
        launch(4'd6, 32'h22, 32'd0);
        n_checks++;
        if (LO !== 32'h22 || HI !== 32'h11 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mtlo_pre: got HI=%h LO=%h busy=%b, required 11/22/0", HI, LO, busy);
        end
        exp_q.push_back({32'h11, 32'h22});
        launch(4'd3, 32'd5, 32'd0);
        wait_idle(cyc, held);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc != 10 || {HI, LO} !== e) begin
            n_fail++; $display("FAIL div_zero: got %0d cyc %h_%h, required 10 cyc %h", cyc, HI, LO, e);
        end
    endtask

    task automatic test_busy_ignore();
        int n; logic [63:0] e;
        exp_q.push_back({32'd2, 32'd14});
        launch(4'd3, 32'd100, 32'd7);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 3) begin start = 1'b1; op = 4'd1; A = 32'd9; B = 32'd9; end
            tick();
            start = 1'b0; op = 4'd0;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (n != 10) begin n_fail++; $display("FAIL ignore_busy: got %0d cycles, required 10", n); end
        n_checks++;
        if ({HI, LO} !== e) begin n_fail++; $display("FAIL ignore_result: got %h_%h, required %h", HI, LO, e); end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_relaunch: busy=%b, required 0", busy); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit held; logic [63:0] e;
        exp_q.push_back({32'd0, 32'd42});
        exp_q.push_back({32'd1, 32'd8});
        launch(4'd2, 32'd6, 32'd7);
        wait_idle(cyc, held);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc != 5 || {HI, LO} !== e) begin
            n_fail++; $display("FAIL b2b_first: got %0d cyc %h_%h, required 5 cyc %h", cyc, HI, LO, e);
        end
        launch(4'd4, 32'd17, 32'd2);
        wait_idle(cyc, held);
        e = exp_q.pop_front();
        n_checks++;
        if (cyc != 10 || {HI, LO} !== e) begin
            n_fail++; $display("FAIL b2b_second: got %0d cyc %h_%h, required 10 cyc %h", cyc, HI, LO, e);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        launch(4'd1, 32'd3, 32'd4);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid: busy=%b HI=%h LO=%h, required 0/0/0", busy, HI, LO);
        end
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++; $display("FAIL reset_no_late_write: busy=%b HI=%h LO=%h, required 0/0/0", busy, HI, LO);
        end
    endtask

    task automatic test_mtlo();
        bit rose;
        launch(4'd5, 32'h0000ABCD, 32'd0);
        launch(4'd6, 32'hDEADBEEF, 32'd0);
        n_checks++;
        if (LO !== 32'hDEADBEEF || HI !== 32'h0000ABCD) begin
            n_fail++; $display("FAIL mtlo: got HI=%h LO=%h, required 0000abcd/deadbeef", HI, LO);
        end
        rose = (busy !== 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy !== 1'b0) rose = 1'b1;
        end
        n_checks++;
        if (rose) begin n_fail++; $display("FAIL mtlo_busy: busy rose, required 0"); end
        launch(4'd9, 32'h12345678, 32'd1);
        n_checks++;
        if (busy !== 1'b0 || HI !== 32'h0000ABCD || LO !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL unknown_op: busy=%b HI=%h LO=%h, required 0/0000abcd/deadbeef", busy, HI, LO);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'd0; A = '0; B = '0;
        test_reset();
        test_mult();
        test_div();
        test_random();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_mtlo();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
